// File: rtl/dncnt_timer.sv
// Loadable down-counter/timer with terminal-count pulse.
// Counts a preset to zero; optionally reloads it for periodic events.
module dncnt_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         en,
  input  logic         auto,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         tc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  logic [0:0]   state;
  logic [0:0]   state_nx;
  logic [W-1:0] rld;
  logic [W-1:0] rld_nx;
  logic [W-1:0] q_nx;
  logic         tc_nx;

  logic run;
  logic do_ld;
  logic do_term;
  logic do_dec;

  assign run     = (state == S_RUN);
  assign do_ld   = ld;
  assign do_term = !ld && run && en && (q == ONE);
  assign do_dec  = !ld && run && en && (q != ONE);

  // Decode is one-hot by construction; hold is the default
  always_comb begin
    state_nx = state;
    rld_nx   = rld;
    q_nx     = q;
    tc_nx    = 1'b0;
    unique case (1'b1)
      do_ld: begin
        q_nx     = d;
        rld_nx   = d;
        state_nx = (d != ZERO) ? S_RUN : S_IDLE;
      end
      do_term: begin
        tc_nx = 1'b1;
        if (auto) begin
          q_nx = rld;
        end else begin
          q_nx     = ZERO;
          state_nx = S_IDLE;
        end
      end
      do_dec: begin
        q_nx = q - ONE;
      end
      default: begin
        q_nx = q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      rld   <= '0;
      q     <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      rld   <= rld_nx;
      q     <= q_nx;
      tc    <= tc_nx;
    end
  end

  assign busy = state[0];

endmodule

// File: tb/tb_dncnt_timer.sv
// Directed bench for dncnt_timer.
// Expected {q,busy,tc} queued at drive time, checked after the edge.
module tb_dncnt_timer;

  localparam int W = 3;

  logic         clk;
  logic         nrst;
  logic         ld;
  logic [W-1:0] d;
  logic         en;
  logic         auto;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W+1:0] sb[$];

  dncnt_timer #(.W(W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .ld   (ld),
    .d    (d),
    .en   (en),
    .auto (auto),
    .q    (q),
    .busy (busy),
    .tc   (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W+1:0] exp);
    logic [W+1:0] obs;
    obs = {q, busy, tc};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed q=%0d busy=%b tc=%b, expected q=%0d busy=%b tc=%b",
             tag, obs[W+1:2], obs[1], obs[0], exp[W+1:2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic i_ld, input logic [W-1:0] i_d,
                     input logic i_en, input logic i_auto,
                     input logic [W-1:0] eq, input logic eb, input logic et);
    logic [W+1:0] exp;
    ld   = i_ld;
    d    = i_d;
    en   = i_en;
    auto = i_auto;
    sb.push_back({eq, eb, et});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    chk(tag, exp);
  endtask

  initial begin
    nrst = 1'b0;
    ld   = 1'b0;
    d    = '0;
    en   = 1'b0;
    auto = 1'b0;
    #12;
    chk("reset", '0);
    nrst = 1'b1;

    // one-shot from 5
    cyc("t1_ld",  1, 5, 1, 0, 5, 1, 0);
    cyc("t1_4",   0, 0, 1, 0, 4, 1, 0);
    cyc("t1_3",   0, 0, 1, 0, 3, 1, 0);
    cyc("t1_2",   0, 0, 1, 0, 2, 1, 0);
    cyc("t1_1",   0, 0, 1, 0, 1, 1, 0);
    cyc("t1_tc",  0, 0, 1, 0, 0, 0, 1);
    cyc("t1_z0",  0, 0, 1, 0, 0, 0, 0);
    cyc("t1_z1",  0, 0, 1, 0, 0, 0, 0);

    // periodic from 3
    cyc("t2_ld",  1, 3, 1, 1, 3, 1, 0);
    cyc("t2_2",   0, 0, 1, 1, 2, 1, 0);
    cyc("t2_1",   0, 0, 1, 1, 1, 1, 0);
    cyc("t2_rl0", 0, 0, 1, 1, 3, 1, 1);
    cyc("t2_2b",  0, 0, 1, 1, 2, 1, 0);
    cyc("t2_1b",  0, 0, 1, 1, 1, 1, 0);
    cyc("t2_rl1", 0, 0, 1, 1, 3, 1, 1);
    cyc("t2_stop",1, 0, 1, 1, 0, 0, 0);

    // gated enable
    cyc("t3_ld",  1, 2, 1, 0, 2, 1, 0);
    cyc("t3_e1",  0, 0, 1, 0, 1, 1, 0);
    cyc("t3_e0a", 0, 0, 0, 0, 1, 1, 0);
    cyc("t3_e0b", 0, 0, 0, 0, 1, 1, 0);
    cyc("t3_tc",  0, 0, 1, 0, 0, 0, 1);

    // load during terminal cycle
    cyc("t4_ld",  1, 4, 0, 0, 4, 1, 0);
    cyc("t4_3",   0, 0, 1, 0, 3, 1, 0);
    cyc("t4_2",   0, 0, 1, 0, 2, 1, 0);
    cyc("t4_1",   0, 0, 1, 0, 1, 1, 0);
    cyc("t4_cut", 1, 6, 1, 0, 6, 1, 0);
    cyc("t4_hold",0, 0, 0, 0, 6, 1, 0);

    // full range, then zero load
    cyc("t5_ld7", 1, 7, 1, 0, 7, 1, 0);
    for (int i = 6; i >= 1; i--)
      cyc("t5_dn", 0, 0, 1, 0, W'(i), 1, 0);
    cyc("t5_tc",  0, 0, 1, 0, 0, 0, 1);
    cyc("t5_rl7", 1, 7, 0, 0, 7, 1, 0);
    cyc("t5_6",   0, 0, 1, 0, 6, 1, 0);
    cyc("t5_ld0", 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc("t5_nowrap", 0, 0, 1, 0, 0, 0, 0);

    // async reset mid-count
    cyc("t6_ld",  1, 5, 1, 0, 5, 1, 0);
    cyc("t6_4",   0, 0, 1, 0, 4, 1, 0);
    cyc("t6_3",   0, 0, 1, 0, 3, 1, 0);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_arst", '0);
    #2;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("t6_idle", 0, 0, 1, 0, 0, 0, 0);
    cyc("t6_reld",1, 3, 1, 0, 3, 1, 0);
    cyc("t6_2",   0, 0, 1, 0, 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
